// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the button-to-CC message path and the transmitter.
package midi_pkg;

    localparam logic [3:0] MIDI_STATUS_CC = 4'hB;

    // 100 MHz clock / 31250 baud / 2
    localparam int unsigned BAUD_CNT_HALF = 1600;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] data1;
        logic [7:0] data2;
    } midi_msg_t;

    typedef struct packed {
        logic [6:0] idx;
        logic       val;
    } cc_evt_t;

endpackage

// File: rtl/midi_btn_debounce.sv
// One button: 2-flop synchroniser followed by a stable-disagreement counter.
// flip is combinational and high in the cycle whose closing edge toggles state.
module midi_btn_debounce
    import midi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic state,
    output logic flip
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        flip    = 1'b0;
        if (sync2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            flip    = 1'b1;
            state_d = ~state_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/midi_cc_msg_gen.sv
// Debounced buttons to MIDI Control Change messages, queued in a show-ahead FIFO
// behind a valid/ready interface.
module midi_cc_msg_gen
    import midi_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [3:0]  CHANNEL         = 4'h0,
    parameter logic [7:0]  FIRST_CC        = 8'd46,
    parameter logic [7:0]  CC_ON           = 8'd127,
    parameter logic [7:0]  CC_OFF          = 8'd0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_BTN-1:0]              btn,
    output logic                          msg_valid,
    input  logic                          msg_ready,
    output logic [7:0]                    msg_status,
    output logic [7:0]                    msg_data1,
    output logic [7:0]                    msg_data2,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          drop,
    output logic [N_BTN-1:0]              btn_state
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (int'(FIRST_CC) + int'(N_BTN) - 1 > 127) begin : g_cc_range_err
        $error("FIRST_CC + N_BTN - 1 exceeds 127");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_err
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [N_BTN-1:0] flip;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        midi_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .state(btn_state[i]),
            .flip (flip[i])
        );
    end

    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] pend_val_q, pend_val_d;
    logic             drop_q, drop_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    cc_evt_t          mem_q [FIFO_DEPTH];

    logic             push_hit;
    logic [N_BTN-1:0] push_sel;
    logic [6:0]       push_idx;
    logic             push_val;
    logic             full, push, pop;

    assign msg_valid = (count_q != '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = msg_valid && msg_ready;
    assign push      = push_hit && (!full || pop);

    // Fixed-priority pick: lowest pending button index goes first.
    always_comb begin
        push_hit = 1'b0;
        push_sel = '0;
        push_idx = '0;
        push_val = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (pend_q[i] && !push_hit) begin
                push_hit    = 1'b1;
                push_sel[i] = 1'b1;
                push_idx    = 7'(i);
                push_val    = pend_val_q[i];
            end
        end
    end

    // A flip on the enqueue edge wins; it only drops if the old value was not queued.
    always_comb begin
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        drop_d     = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (push && push_sel[i]) begin
                pend_d[i] = 1'b0;
            end
            if (flip[i]) begin
                if (pend_d[i]) begin
                    drop_d = 1'b1;
                end
                pend_d[i]     = 1'b1;
                pend_val_d[i] = ~btn_state[i];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q     <= '0;
            pend_val_q <= '0;
            drop_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cc_evt_t'{idx: push_idx, val: push_val};
        end
    end

    cc_evt_t   head;
    midi_msg_t msg;

    assign head = mem_q[rd_ptr_q];

    // Outputs are forced to zero when empty so stale storage never shows.
    always_comb begin
        msg = '0;
        if (msg_valid) begin
            msg.status = {MIDI_STATUS_CC, CHANNEL};
            msg.data1  = FIRST_CC + {1'b0, head.idx};
            msg.data2  = head.val ? CC_ON : CC_OFF;
        end
    end

    assign msg_status = msg.status;
    assign msg_data1  = msg.data1;
    assign msg_data2  = msg.data2;
    assign fifo_count = count_q;
    assign drop       = drop_q;

endmodule
